// File: rtl/tetris_key_pkg.sv
// Shared types and default timing for the Tetris key conditioning logic.
// Defaults assume a 50 MHz system clock.
package tetris_key_pkg;

  localparam int KEY_CNT_W           = 24;
  localparam int KEY_DEBOUNCE_CYCLES = 500000;
  localparam int KEY_REPEAT_DELAY    = 15000000;
  localparam int KEY_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/tetris_key_sync.sv
// Two-flop synchroniser for a raw active-low key pin.
// Resets to 1 so an unpressed key is assumed until the pin says otherwise.
module tetris_key_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/tetris_key_debounce.sv
// Debounce FSM with auto-repeat for one Tetris push-button.
// Produces a clean level for the PIO and one-cycle event strobes.
module tetris_key_debounce
  import tetris_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int REPEAT_ENABLE   = 1,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD,
  parameter int CNT_W           = KEY_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic action_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             first_q, first_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rpt_q, rpt_d;
  logic             act_q;
  logic             key_n_sync;
  logic             raw;

  tetris_key_sync u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (key_n_in),
    .q_o   (key_n_sync)
  );

  assign raw = ~key_n_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      deb_q   <= '0;
      rep_q   <= '0;
      first_q <= 1'b1;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      rep_q   <= rep_d;
      first_q <= first_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      act_q   <= press_d | rpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    first_d = first_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        deb_d = '0;
        if (raw) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_d = RELEASED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          deb_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      PRESSED: begin
        deb_d = '0;
        // rep_q is left untouched on the way out so a glitch resumes it
        if (!raw) begin
          state_d = RELEASE_WAIT;
        end else if (REPEAT_ENABLE != 0) begin
          if (rep_q == (first_q ? DLY_LAST : PER_LAST)) begin
            rpt_d   = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (raw) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = RELEASED;
          deb_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        deb_d   = '0;
      end
    endcase
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rpt_q;
  assign action_pulse  = act_q;

endmodule

// File: tb/tb_tetris_key_debounce.sv
// Directed bench for tetris_key_debounce with short timing parameters.
// Output vector order: {level, press, release, repeat, action}.
module tb_tetris_key_debounce;

  logic clk = 1'b0;
  logic reset;
  logic key_n_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic action_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       key;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [1:62];

  always #5 clk = ~clk;

  tetris_key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_ENABLE   (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n_in      (key_n_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .action_pulse  (action_pulse)
  );

  function automatic logic [4:0] ev(input logic l, input logic p,
                                    input logic r, input logic rp);
    return {l, p, r, rp, p | rp};
  endfunction

  function automatic logic [4:0] outs();
    return {key_level, press_pulse, release_pulse,
            repeat_pulse, action_pulse};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // table: bounce, press, repeats, release glitch, clean release
    for (int t = 1; t <= 62; t++) begin
      logic lo;
      lo = (t >= 4 && t <= 23 && ((t - 4) % 4) != 3) ||
           (t >= 24 && t <= 40) ||
           (t >= 43 && t <= 49);
      vecs[t].key = ~lo;
      vecs[t].exp = ev(t >= 30 && t <= 55, t == 30, t == 56,
                       t == 40 || t == 46 || t == 49);
    end

    reset    = 1'b1;
    key_n_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset", i, outs(), 5'b0);
    end
    reset = 1'b0;

    // held key through reset exit: press at 7, repeats, release at 31
    for (int e = 1; e <= 31; e++) begin
      tick();
      check("reset_exit", e, outs(),
            ev(e >= 7 && e < 31, e == 7, e == 31,
               e == 17 || e == 20 || e == 23 || e == 26));
      if (e == 24) key_n_in = 1'b1;
    end

    repeat (4) tick();

    for (int t = 1; t <= 62; t++) begin
      key_n_in = vecs[t].key;
      tick();
      check("table", t, outs(), vecs[t].exp);
    end

    // press and hold until rep_cnt reaches 5, then reset mid-press
    key_n_in = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("press2", e, outs(), ev(e >= 7, e == 7, 1'b0, 1'b0));
    end
    reset = 1'b1;
    #1;
    check("async_reset", 0, outs(), 5'b0);
    key_n_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("post_reset_quiet", e, outs(), 5'b0);
    end

    key_n_in = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("press3", e, outs(), ev(e == 7, e == 7, 1'b0, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
